// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side command path: byte width,
// command codes, timeout default and the decoder state encoding.
package uart_pkg;

  localparam int unsigned UART_DBIT          = 8;
  localparam logic [7:0]  UART_CMD_START     = 8'h53;
  localparam logic [7:0]  UART_CMD_LOAD      = 8'h4C;
  localparam int unsigned UART_TIMEOUT_TICKS = 1024;
  localparam int unsigned UART_TW            = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GET_LO = 2'b01,
    GET_HI = 2'b10
  } rx_state_e;

endpackage

// File: rtl/uart_rx_cmd_decoder_if.sv
// Byte-in / word-out bundle between the UART receiver, the command decoder and
// the BIP core. The decoder sits on the slave side and the environment on the master side.
interface uart_rx_cmd_decoder_if #(
  parameter int unsigned DBIT = uart_pkg::UART_DBIT
) ();

  logic              tick;
  logic [DBIT-1:0]   rx_data;
  logic              rx_done_tick;
  logic              word_ack;
  logic [2*DBIT-1:0] word;
  logic              word_valid;
  logic              start_bip;
  logic              cmd_err;
  logic              timeout_err;
  logic              overrun_err;

  modport master (
    output tick, rx_data, rx_done_tick, word_ack,
    input  word, word_valid, start_bip, cmd_err, timeout_err, overrun_err
  );

  modport slave (
    input  tick, rx_data, rx_done_tick, word_ack,
    output word, word_valid, start_bip, cmd_err, timeout_err, overrun_err
  );

endinterface

// File: rtl/uart_tick_timeout.sv
// Baud-tick watchdog. It counts ticks while enabled and pulses expire_o on the
// tick that would take the count past TIMEOUT_TICKS-1.
module uart_tick_timeout #(
  parameter int unsigned TIMEOUT_TICKS = 1024,
  parameter int unsigned TW            = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT_TICKS - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          expire;

  assign expire   = en_i && tick_i && (cnt_q == LAST_COUNT);
  assign expire_o = expire;

  // Wrap to zero on expiry so a stale count never leaks into the next frame.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire) begin
      cnt_d = '0;
    end else if (en_i && tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Parses START / LOAD commands from the UART byte stream. LOAD operands are
// assembled low byte first into a held, acknowledged word for the BIP core.
module uart_rx_cmd_decoder
  import uart_pkg::*;
#(
  parameter int unsigned     DBIT          = UART_DBIT,
  parameter logic [DBIT-1:0] CMD_START     = UART_CMD_START,
  parameter logic [DBIT-1:0] CMD_LOAD      = UART_CMD_LOAD,
  parameter int unsigned     TIMEOUT_TICKS = UART_TIMEOUT_TICKS,
  parameter int unsigned     TW            = UART_TW
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_rx_cmd_decoder_if.slave bus
);

  rx_state_e         state_q, state_d;
  logic [DBIT-1:0]   lo_q, lo_d;
  logic [2*DBIT-1:0] word_q, word_d;
  logic              wordValid_q, wordValid_d;
  logic              startBip_q, startBip_d;
  logic              cmdErr_q, cmdErr_d;
  logic              timeoutErr_q, timeoutErr_d;
  logic              overrunErr_q, overrunErr_d;

  logic inFrame;
  logic cntClr;
  logic expire;
  logic timedOut;

  assign inFrame  = (state_q != IDLE);
  assign cntClr   = !inFrame || bus.rx_done_tick;
  assign timedOut = inFrame && expire && !bus.rx_done_tick;

  uart_tick_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .TW            (TW)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cntClr),
    .en_i     (inFrame),
    .tick_i   (bus.tick),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lo_q         <= '0;
      word_q       <= '0;
      wordValid_q  <= 1'b0;
      startBip_q   <= 1'b0;
      cmdErr_q     <= 1'b0;
      timeoutErr_q <= 1'b0;
      overrunErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      word_q       <= word_d;
      wordValid_q  <= wordValid_d;
      startBip_q   <= startBip_d;
      cmdErr_q     <= cmdErr_d;
      timeoutErr_q <= timeoutErr_d;
      overrunErr_q <= overrunErr_d;
    end
  end

  // Inside a frame every byte is payload, so command codes are only decoded in IDLE.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.rx_done_tick && (bus.rx_data == CMD_LOAD)) begin
          state_d = GET_LO;
        end
      end
      GET_LO: begin
        if (bus.rx_done_tick) begin
          lo_d    = bus.rx_data;
          state_d = GET_HI;
        end else if (timedOut) begin
          lo_d    = '0;
          state_d = IDLE;
        end
      end
      GET_HI: begin
        if (bus.rx_done_tick) begin
          state_d = IDLE;
        end else if (timedOut) begin
          lo_d    = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A completing word may replace the held one only if it is free or acked this cycle.
  always_comb begin
    startBip_d   = (state_q == IDLE) && bus.rx_done_tick && (bus.rx_data == CMD_START);
    cmdErr_d     = (state_q == IDLE) && bus.rx_done_tick &&
                   (bus.rx_data != CMD_START) && (bus.rx_data != CMD_LOAD);
    timeoutErr_d = timedOut;
    overrunErr_d = 1'b0;
    word_d       = word_q;
    wordValid_d  = wordValid_q;
    if (wordValid_q && bus.word_ack) begin
      wordValid_d = 1'b0;
    end
    if ((state_q == GET_HI) && bus.rx_done_tick) begin
      if (!wordValid_q || bus.word_ack) begin
        word_d      = {bus.rx_data, lo_q};
        wordValid_d = 1'b1;
      end else begin
        overrunErr_d = 1'b1;
      end
    end
  end

  assign bus.word        = word_q;
  assign bus.word_valid  = wordValid_q;
  assign bus.start_bip   = startBip_q;
  assign bus.cmd_err     = cmdErr_q;
  assign bus.timeout_err = timeoutErr_q;
  assign bus.overrun_err = overrunErr_q;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Directed bench for uart_rx_cmd_decoder: bytes are driven one cycle at a time
// and every output is checked against hand-computed values one clk later.
module tb_uart_rx_cmd_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   compareCount = 0;
  int   failCount    = 0;

  uart_rx_cmd_decoder_if bus ();

  uart_rx_cmd_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkPulses(input string tag, input logic s, input logic c,
                             input logic t, input logic o);
    checkOutput({tag, ".start_bip"},   16'(bus.start_bip),   16'(s));
    checkOutput({tag, ".cmd_err"},     16'(bus.cmd_err),     16'(c));
    checkOutput({tag, ".timeout_err"}, 16'(bus.timeout_err), 16'(t));
    checkOutput({tag, ".overrun_err"}, 16'(bus.overrun_err), 16'(o));
  endtask

  task automatic checkWord(input string tag, input logic v, input logic [15:0] w);
    checkOutput({tag, ".word_valid"}, 16'(bus.word_valid), 16'(v));
    checkOutput({tag, ".word"},       bus.word,            w);
  endtask

  // One received byte: rx_done_tick high for exactly one sampled cycle.
  task automatic applyStimulus(input logic [7:0] b);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    stepClk();
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic giveTicks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      stepClk();
      bus.tick = 1'b0;
      stepClk();
    end
  endtask

  task automatic ackWord();
    bus.word_ack = 1'b1;
    stepClk();
    bus.word_ack = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.tick         = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rx_done_tick = 1'b0;
    bus.word_ack     = 1'b0;
    repeat (2) stepClk();
    checkPulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkWord("reset", 1'b0, 16'h0000);
    rst_n = 1'b1;
    stepClk();

    $display("[TB] START command");
    applyStimulus(8'h53);
    checkPulses("start", 1'b1, 1'b0, 1'b0, 1'b0);
    checkWord("start", 1'b0, 16'h0000);
    stepClk();
    checkPulses("start_end", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] LOAD 0x1234 and handshake");
    applyStimulus(8'h4C);
    checkWord("load1_cmd", 1'b0, 16'h0000);
    applyStimulus(8'h34);
    applyStimulus(8'h12);
    checkWord("load1", 1'b1, 16'h1234);
    checkPulses("load1", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) stepClk();
    checkWord("load1_hold", 1'b1, 16'h1234);
    ackWord();
    checkWord("load1_acked", 1'b0, 16'h1234);

    $display("[TB] command codes inside a frame are data");
    applyStimulus(8'h4C);
    applyStimulus(8'h53);
    checkPulses("load2_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h4C);
    checkWord("load2", 1'b1, 16'h4C53);
    checkPulses("load2", 1'b0, 1'b0, 1'b0, 1'b0);
    ackWord();
    checkWord("load2_acked", 1'b0, 16'h4C53);

    $display("[TB] inter-byte timeout");
    applyStimulus(8'h4C);
    applyStimulus(8'h01);
    giveTicks(1023);
    checkPulses("to_before", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.tick = 1'b1;
    stepClk();
    bus.tick = 1'b0;
    checkPulses("to_fire", 1'b0, 1'b0, 1'b1, 1'b0);
    checkWord("to_fire", 1'b0, 16'h4C53);
    stepClk();
    checkPulses("to_end", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h53);
    checkPulses("to_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    stepClk();

    $display("[TB] byte on the expiring tick is accepted");
    applyStimulus(8'h4C);
    giveTicks(1023);
    bus.tick = 1'b1;
    applyStimulus(8'h22);
    bus.tick = 1'b0;
    checkPulses("to_race", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h11);
    checkWord("to_race", 1'b1, 16'h1122);
    ackWord();

    $display("[TB] overrun");
    applyStimulus(8'h4C);
    applyStimulus(8'hAA);
    applyStimulus(8'hAA);
    checkWord("ovr_first", 1'b1, 16'hAAAA);
    applyStimulus(8'h4C);
    applyStimulus(8'h55);
    applyStimulus(8'h55);
    checkPulses("ovr", 1'b0, 1'b0, 1'b0, 1'b1);
    checkWord("ovr", 1'b1, 16'hAAAA);
    stepClk();
    checkPulses("ovr_end", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h4C);
    applyStimulus(8'h55);
    bus.word_ack = 1'b1;
    applyStimulus(8'h55);
    bus.word_ack = 1'b0;
    checkPulses("ack_race", 1'b0, 1'b0, 1'b0, 1'b0);
    checkWord("ack_race", 1'b1, 16'h5555);

    $display("[TB] unknown command and mid-frame reset");
    applyStimulus(8'h7F);
    checkPulses("cmd_err", 1'b0, 1'b1, 1'b0, 1'b0);
    checkWord("cmd_err", 1'b1, 16'h5555);
    stepClk();
    checkPulses("cmd_err_end", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h4C);
    applyStimulus(8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    checkPulses("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkWord("async_rst", 1'b0, 16'h0000);
    stepClk();
    rst_n = 1'b1;
    giveTicks(3);
    checkPulses("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h12);
    checkPulses("post_rst_byte", 1'b0, 1'b1, 1'b0, 1'b0);
    checkWord("post_rst_byte", 1'b0, 16'h0000);
    stepClk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: sequence did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_rx_cmd_decoder.md
Name: uart_rx_cmd_decoder

Overview:
- Sits between the UART Receiver and the BIP processor core.
- Consumes the byte stream from the Receiver (byte + done-tick), parses a simple command protocol and reassembles 16-bit operands low byte first, the same ordering the TX path uses.
- Produces a one-cycle start pulse for the processor and a held, acknowledged word interface.
- Guards LOAD frames with an inter-byte timeout measured in baud ticks, and reports protocol errors.

Parameters:
- DBIT, 8, byte width from the Receiver; word width is 2*DBIT.
- CMD_START, 8'h53, command byte that requests a processor start.
- CMD_LOAD, 8'h4C, command byte followed by two data bytes, low then high.
- TIMEOUT_TICKS, 1024, baud ticks (16x oversample) allowed between bytes of one frame.
- TW, 11, timeout counter width; must satisfy 2^TW > TIMEOUT_TICKS.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  baud-rate generator sample tick, one clk cycle wide.
- rx_data  in  DBIT  received byte, valid when rx_done_tick=1.
- rx_done_tick  in  1  one-cycle strobe from the Receiver.
- word_ack  in  1  consumer has taken word; sampled only while word_valid=1.
- word  out  2*DBIT  assembled operand {hi,lo}.
- word_valid  out  1  word holds unconsumed data.
- start_bip  out  1  one-cycle start pulse.
- cmd_err  out  1  one-cycle pulse on an unknown command byte.
- timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout.
- overrun_err  out  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, word=0, state=IDLE, timeout counter=0, low-byte latch=0.
- All logic is registered on posedge clk. Every output is driven directly from a flop.
- FSM states and transitions:
  - IDLE, on rx_done_tick:
    - rx_data==CMD_START: start_bip=1 on the next cycle; stay IDLE.
    - rx_data==CMD_LOAD: go to GET_LO; clear the timeout counter.
    - any other value: cmd_err=1 for one cycle; stay IDLE.
  - GET_LO, on rx_done_tick: latch rx_data as the low byte; clear the counter; go to GET_HI.
  - GET_HI, on rx_done_tick: complete the word {rx_data, lo}; go to IDLE.
- Command bytes are not interpreted inside GET_LO/GET_HI. 0x53 or 0x4C there is data.
- Timeout:
  - In GET_LO/GET_HI the counter increments on each tick.
  - When the counter reaches TIMEOUT_TICKS-1 and a tick arrives with no rx_done_tick in that cycle:
    - pulse timeout_err;
    - discard the partial frame;
    - go to IDLE.
  - rx_done_tick in the same cycle as the expiring tick wins; the byte is accepted.
  - In IDLE the counter is held at 0.
- Word completion in GET_HI:
  - word_valid=0, or word_ack=1 in the same cycle: word is loaded and word_valid=1 on the next cycle. Simultaneous ack and completion is not an overrun.
  - word_valid=1 and word_ack=0: the new word is dropped, the old word is kept, overrun_err pulses.
- Handshake:
  - word_valid stays 1 and word stays stable until the cycle after word_ack=1; then word_valid=0.
  - word itself keeps its last value.
- Latency: start_bip, cmd_err and word_valid assert one clk after the triggering rx_done_tick.
- Pulse outputs (start_bip, cmd_err, timeout_err, overrun_err) are exactly one clk wide. They are never stretched or merged.
- Reset asserted mid-frame aborts the frame immediately; no error pulse is produced.
- rx_done_tick while in IDLE never affects a pending word_valid.

Decomposition:
- Shared package uart_pkg holds:
  - the DBIT default;
  - CMD_START and CMD_LOAD codes;
  - the FSM state encoding (IDLE=2'b00, GET_LO=2'b01, GET_HI=2'b10);
  - the TIMEOUT_TICKS default.
- One sub-module is natural: uart_tick_timeout. It is a tick-driven counter with clear and enable inputs and a single-cycle expire output, reusable by a future TX-side watchdog.
- The FSM and the word register stay in the top module.

Test Plan:
- Reset, then byte 0x53 -> start_bip=1 for exactly one clk, one cycle after rx_done_tick; all other outputs stay 0.
- Bytes 0x4C, 0x34, 0x12 -> word=16'h1234 with word_valid=1; word_ack after 5 clks -> word_valid=0 on the next clk, word still 16'h1234.
- Bytes 0x4C, 0x53, 0x4C -> word=16'h4C53; no start_bip pulse.
- 0x4C, 0x01, then no bytes for 1024 ticks -> timeout_err one pulse; then 0x53 -> start_bip (FSM back in IDLE, partial frame discarded).
- Word 0xAAAA pending and unacked; frame 0x4C, 0x55, 0x55 -> overrun_err pulse, word stays 16'hAAAA. Repeat with word_ack coincident with the final byte -> word=16'h5555 and no overrun_err.
- Byte 0x7F -> cmd_err pulse. Then reset asserted in GET_HI -> all outputs 0 asynchronously, with no error pulse after release.
